// File: rtl/ws_pkg.sv
// Shared types and constants for the WS2812B frame sequencer.
package ws_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_LOAD,
        ST_SEND,
        ST_WAIT,
        ST_LATCH
    } ws_seq_state_t;

    localparam int WS_BITS_PER_PIXEL = 24;
    localparam int WS_CLK_HZ         = 12_000_000;
    localparam int WS_LATCH_CYCLES   = 960;
    localparam int WS_TIMEOUT_CYCLES = 1024;

    function automatic int ws_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws_cycle_timer.sv
// Loadable down-counter that parks at zero; tc flags the terminal count.
module ws_cycle_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ws_frame_sequencer.sv
// Frame scheduler for a WS2812B chain: snapshot, per-pixel load/send, latch gap.
// Define WS_SERPENTINE_EN to remap pixel for serpentine-wired 8x8 panels.
module ws_frame_sequencer
    import ws_pkg::*;
#(
    parameter int NUM_PIXELS     = 64,
    parameter int PIX_W          = 6,
    parameter int LATCH_CYCLES   = WS_LATCH_CYCLES,
    parameter int TIMEOUT_CYCLES = WS_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_req,
    input  logic             pixel_done,
    output logic             snap,
    output logic             load_sreg,
    output logic             transmit_pixel,
    output logic [PIX_W-1:0] pixel,
    output logic             busy,
    output logic             frame_done,
    output logic             timeout_err
);

    localparam int LW = $clog2(LATCH_CYCLES);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int CW = ws_max(ws_max(LW, TW), 1);

    localparam logic [CW-1:0] LATCH_LOAD   = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(NUM_PIXELS - 1);

    ws_seq_state_t    state;
    ws_seq_state_t    state_nx;
    logic [PIX_W-1:0] pix_q;
    logic             pending;
    logic             last_pix;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_en;
    logic             tmr_tc;

    assign last_pix = (pix_q == LAST_PIX);

    // One timer serves both the WAIT watchdog and the LATCH gap.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = LATCH_LOAD;
        tmr_en   = (state == ST_WAIT) || (state == ST_LATCH);
        if (state == ST_SEND) begin
            tmr_load = 1'b1;
            tmr_val  = TIMEOUT_LOAD;
        end else if (state == ST_WAIT) begin
            tmr_load = pixel_done ? last_pix : tmr_tc;
        end
    end

    ws_cycle_timer #(
        .W(CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (frame_req || pending) state_nx = ST_SNAP;
            ST_SNAP:  state_nx = ST_LOAD;
            ST_LOAD:  state_nx = ST_SEND;
            ST_SEND:  state_nx = ST_WAIT;
            ST_WAIT: begin
                if (pixel_done) begin
                    state_nx = last_pix ? ST_LATCH : ST_LOAD;
                end else if (tmr_tc) begin
                    state_nx = ST_LATCH;
                end
            end
            ST_LATCH: if (tmr_tc) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pix_q       <= '0;
            pending     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE) begin
                pending <= 1'b0;
            end else if (frame_req) begin
                pending <= 1'b1;
            end
            if (state == ST_SNAP || (state == ST_LATCH && tmr_tc)) begin
                pix_q <= '0;
            end else if (state == ST_WAIT && pixel_done && !last_pix) begin
                pix_q <= pix_q + 1'b1;
            end
            if (state == ST_WAIT && !pixel_done && tmr_tc) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign snap           = (state == ST_SNAP);
    assign load_sreg      = (state == ST_LOAD);
    assign transmit_pixel = (state == ST_SEND);
    assign busy           = (state != ST_IDLE);
    assign frame_done     = (state == ST_LATCH) && tmr_tc;

`ifdef WS_SERPENTINE_EN
    // Odd rows run right-to-left on the panel.
    assign pixel = pix_q[3] ? {pix_q[5:3], ~pix_q[2:0]} : pix_q;
`else
    assign pixel = pix_q;
`endif

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Self-checking bench for ws_frame_sequencer: vector table, random frames, corners.
module tb_ws_frame_sequencer;

    localparam int NPIX = 64;
    localparam int PW   = 6;
    localparam int LAT  = 40;
    localparam int TMO  = 64;

    localparam int K_SNAP  = 0;
    localparam int K_LOAD  = 1;
    localparam int K_SEND  = 2;
    localparam int K_FDONE = 3;
    localparam int K_TERR  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          frame_req = 1'b0;
    logic          pixel_done = 1'b0;
    logic          snap;
    logic          load_sreg;
    logic          transmit_pixel;
    logic [PW-1:0] pixel;
    logic          busy;
    logic          frame_done;
    logic          timeout_err;

    ws_frame_sequencer #(
        .NUM_PIXELS     (NPIX),
        .PIX_W          (PW),
        .LATCH_CYCLES   (LAT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_req      (frame_req),
        .pixel_done     (pixel_done),
        .snap           (snap),
        .load_sreg      (load_sreg),
        .transmit_pixel (transmit_pixel),
        .pixel          (pixel),
        .busy           (busy),
        .frame_done     (frame_done),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int kind;
        int pix;
    } ev_t;

    typedef struct {
        logic       rst;
        logic       req;
        logic       pd;
        logic [5:0] exp_out;
        int         pix;
    } vec_t;

    ev_t act[$];
    ev_t expq[$];
    int  dq[$];
    bit  req_map[int];

    int cyc = 0;
    int done_at = -1;
    int busy_cnt = 0;
    int busy_exp = 0;
    bit exp_terr = 0;
    bit force_pd = 0;
    logic terr_prev = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    function automatic int pix_map(input int i);
        int r;
        int c;
        r = i / 8;
        c = i % 8;
`ifdef WS_SERPENTINE_EN
        if (r % 2 == 1) c = 7 - c;
`endif
        return r * 8 + c;
    endfunction

    // Driver delay (cycles from transmit_pixel to pixel_done); -1 withholds.
    function automatic int draw(input int f, input int i);
        int r;
        if (f == 0 && i == 5) return TMO;
        if (f == 0 && i == 9) return 1;
        if (f == 1 && i == 17) return -1;
        r = $urandom_range(0, 199);
        if (f >= 2 && r == 0) return TMO + 1 + $urandom_range(0, LAT - 1);
        return $urandom_range(1, 10);
    endfunction

    task automatic chk(input string nm, input int got, input int want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic chk_ev(input string nm, input int i);
        n_tests++;
        if (i >= act.size() || i >= expq.size()) begin
            n_fail++;
            $display("FAIL %s[%0d]: act_n=%0d exp_n=%0d",
                     nm, i, act.size(), expq.size());
        end else if (act[i] != expq[i]) begin
            n_fail++;
            $display("FAIL %s[%0d]: got c=%0d k=%0d p=%0d want c=%0d k=%0d p=%0d",
                     nm, i, act[i].cyc, act[i].kind, act[i].pix,
                     expq[i].cyc, expq[i].kind, expq[i].pix);
        end
    endtask

    // One cycle: observe this cycle's outputs, then drive this cycle's inputs.
    task automatic tick();
        int d;
        @(negedge clk);
        cyc++;
        if (snap) act.push_back(ev_t'{cyc, K_SNAP, int'(pixel)});
        if (load_sreg) act.push_back(ev_t'{cyc, K_LOAD, int'(pixel)});
        if (transmit_pixel) act.push_back(ev_t'{cyc, K_SEND, int'(pixel)});
        if (frame_done) act.push_back(ev_t'{cyc, K_FDONE, int'(pixel)});
        if (timeout_err && !terr_prev) act.push_back(ev_t'{cyc, K_TERR, int'(pixel)});
        terr_prev = timeout_err;
        busy_cnt += int'(busy);
        if (transmit_pixel) begin
            d = (dq.size() > 0) ? dq.pop_front() : 1;
            done_at = (d < 0) ? -1 : cyc + d;
        end
        pixel_done = force_pd || (cyc == done_at);
        frame_req = req_map.exists(cyc);
    endtask

    task automatic plan_frame(input int f, input int s, output int fd);
        int l;
        int e;
        int last;
        int d;
        l = s + 1;
        e = 0;
        last = 0;
        expq.push_back(ev_t'{s, K_SNAP, pix_map(0)});
        for (int i = 0; i < NPIX; i++) begin
            d = draw(f, i);
            dq.push_back(d);
            expq.push_back(ev_t'{l, K_LOAD, pix_map(i)});
            expq.push_back(ev_t'{l + 1, K_SEND, pix_map(i)});
            last = i;
            if (d < 0 || d > TMO) begin
                e = l + 1 + TMO;
                if (!exp_terr) expq.push_back(ev_t'{e + 1, K_TERR, pix_map(i)});
                exp_terr = 1;
                break;
            end
            if (i == NPIX - 1) e = l + 1 + d;
            else l = l + 2 + d;
        end
        fd = e + LAT;
        expq.push_back(ev_t'{fd, K_FDONE, pix_map(last)});
        busy_exp += fd - s + 1;
    endtask

    vec_t tbl[18];

    initial begin
        int rq[$];
        int p;
        int fd;
        int s;
        int f;
        int base;
        int last;
        int n;
        int r;
        bit pend;
        bit seen;
        logic [5:0] got;

        // {rst, req, pd} applied after checking {snap,load,tx,busy,fdone,terr}
        tbl[0]  = vec_t'{1'b1, 1'b0, 1'b0, 6'b000000, 0};
        tbl[1]  = vec_t'{1'b0, 1'b0, 1'b0, 6'b000000, 0};
        tbl[2]  = vec_t'{1'b0, 1'b0, 1'b1, 6'b000000, 0};
        tbl[3]  = vec_t'{1'b0, 1'b1, 1'b0, 6'b000000, 0};
        tbl[4]  = vec_t'{1'b0, 1'b0, 1'b0, 6'b100100, 0};
        tbl[5]  = vec_t'{1'b0, 1'b0, 1'b0, 6'b010100, 0};
        tbl[6]  = vec_t'{1'b0, 1'b0, 1'b0, 6'b001100, 0};
        tbl[7]  = vec_t'{1'b0, 1'b0, 1'b0, 6'b000100, 0};
        tbl[8]  = vec_t'{1'b0, 1'b0, 1'b1, 6'b000100, 0};
        tbl[9]  = vec_t'{1'b0, 1'b0, 1'b1, 6'b010100, 1};
        tbl[10] = vec_t'{1'b0, 1'b1, 1'b0, 6'b001100, 1};
        tbl[11] = vec_t'{1'b0, 1'b0, 1'b1, 6'b000100, 1};
        tbl[12] = vec_t'{1'b0, 1'b0, 1'b0, 6'b010100, 2};
        tbl[13] = vec_t'{1'b1, 1'b0, 1'b0, 6'b001100, 2};
        tbl[14] = vec_t'{1'b0, 1'b0, 1'b0, 6'b000000, 0};
        tbl[15] = vec_t'{1'b0, 1'b0, 1'b0, 6'b000000, 0};
        tbl[16] = vec_t'{1'b0, 1'b0, 1'b0, 6'b000000, 0};
        tbl[17] = vec_t'{1'b0, 1'b0, 1'b0, 6'b000000, 0};

        #1 rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            got = {snap, load_sreg, transmit_pixel, busy, frame_done, timeout_err};
            n_tests++;
            if (got !== tbl[i].exp_out || int'(pixel) != tbl[i].pix) begin
                n_fail++;
                $display("FAIL vec[%0d]: got %b pix %0d want %b pix %0d",
                         i, got, pixel, tbl[i].exp_out, tbl[i].pix);
            end
            rst = tbl[i].rst;
            frame_req = tbl[i].req;
            pixel_done = tbl[i].pd;
        end
        frame_req = 1'b0;
        pixel_done = 1'b0;

        // Random frames against a frame-level timeline model.
        base = cyc + 1;
        req_map[base + 2] = 1;
        req_map[base + 50] = 1;
        req_map[base + 80] = 1;
        req_map[base + 200] = 1;
        for (int i = 0; i < 6; i++) req_map[base + $urandom_range(300, 4000)] = 1;
        foreach (req_map[k]) rq.push_back(k);
        p = 0;
        fd = 0;
        f = 0;
        pend = 0;
        while (1'b1) begin
            if (pend) begin
                s = fd + 2;
                while (p < rq.size() && rq[p] <= fd + 1) p++;
                pend = 0;
            end else begin
                if (p >= rq.size()) break;
                s = rq[p] + 1;
                p++;
            end
            plan_frame(f, s, fd);
            f++;
            while (p < rq.size() && rq[p] <= fd) begin
                pend = 1;
                p++;
            end
        end
        last = expq[$].cyc;
        if (rq[$] > last) last = rq[$];
        last += 50;
        while (cyc < last) tick();

        n = (act.size() > expq.size()) ? act.size() : expq.size();
        for (int i = 0; i < n; i++) chk_ev("frame_ev", i);
        chk("busy_cycles", busy_cnt, busy_exp);
        chk("terr_sticky", int'(timeout_err), int'(exp_terr));

        // Spurious pixel_done while idle.
        act.delete();
        force_pd = 1;
        repeat (5) tick();
        force_pd = 0;
        chk("idle_spurious", act.size(), 0);

        // Asynchronous reset while waiting on pixel 40.
        dq.delete();
        repeat (NPIX) dq.push_back(3);
        req_map.delete();
        req_map[cyc + 1] = 1;
        seen = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            tick();
            if (act.size() > 0 && act[$].kind == K_SEND && act[$].pix == pix_map(40))
                seen = 1;
        end
        chk("reach_pix40", int'(seen), 1);
        tick();
        #2 rst = 1'b1;
        #1 chk("async_rst",
               int'({snap, load_sreg, transmit_pixel, busy, frame_done, timeout_err, pixel}), 0);
        done_at = -1;
        tick();
        rst = 1'b0;
        act.delete();
        expq.delete();
        r = cyc + 2;
        req_map[r] = 1;
        repeat (6) tick();
        expq.push_back(ev_t'{r + 1, K_SNAP, pix_map(0)});
        expq.push_back(ev_t'{r + 2, K_LOAD, pix_map(0)});
        expq.push_back(ev_t'{r + 3, K_SEND, pix_map(0)});
        for (int i = 0; i < 3; i++) chk_ev("post_rst", i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

endmodule
